// File: rtl/disp_pkg.sv
// Shared constants for the display scan controller.
// Optional leading-zero blanking is selected with DISP_LZ_BLANK_EN.
package disp_pkg;
  localparam int          DIG_W        = 4;
  localparam logic [3:0]  BLANK_CODE   = 4'hF;
  localparam int          DEF_NDIG     = 4;
  localparam int          DEF_PRESCALE = 50000;
  localparam int          DEF_GUARD    = 500;
endpackage

// File: rtl/disp_scan_timer.sv
// Slot/digit counters for the display scan; flags the guard interval and the
// last cycle of the frame (the cycle whose closing edge wraps idx to 0).
import disp_pkg::*;

module disp_scan_timer #(
  parameter int NDIG     = DEF_NDIG,
  parameter int PRESCALE = DEF_PRESCALE,
  parameter int GUARD    = DEF_GUARD,
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1,
  localparam int CW = $clog2(PRESCALE)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [IW-1:0] idx,
  output logic          in_guard,
  output logic          frame_wrap
);
  logic [CW-1:0] slot_cnt;
  logic          slot_end, idx_end;

  assign slot_end   = (slot_cnt == CW'(PRESCALE-1));
  assign idx_end    = (idx == IW'(NDIG-1));
  assign in_guard   = (slot_cnt < CW'(GUARD));
  assign frame_wrap = slot_end && idx_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt <= '0;
      idx      <= '0;
    end else if (slot_end) begin
      slot_cnt <= '0;
      idx      <= idx_end ? '0 : idx + IW'(1);
    end else begin
      slot_cnt <= slot_cnt + CW'(1);
    end
  end
endmodule

// File: rtl/disp_scan_ctrl.sv
// Multiplexed 7-segment scan controller: double-buffered BCD value, guard
// blanking, frame-boundary transfer. DISP_LZ_BLANK_EN enables leading-zero blanking.
import disp_pkg::*;

module disp_scan_ctrl #(
  parameter int NDIG     = DEF_NDIG,
  parameter int PRESCALE = DEF_PRESCALE,
  parameter int GUARD    = DEF_GUARD,
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DIG_W*NDIG-1:0] value_bcd,
  output logic [DIG_W-1:0]      digit_bcd,
  output logic [NDIG-1:0]       digit_sel,
  output logic                  frame_tick,
  output logic                  pending
);
  logic [NDIG-1:0][DIG_W-1:0] shadow, active;
  logic [NDIG-1:0]            lz;
  logic [IW-1:0]              idx;
  logic                       in_guard, frame_wrap;
  logic [1:0]                 vld_pipe;

  disp_scan_timer #(.NDIG(NDIG), .PRESCALE(PRESCALE), .GUARD(GUARD)) u_timer (
    .clk(clk), .rst(rst), .idx(idx), .in_guard(in_guard), .frame_wrap(frame_wrap)
  );

  // Per-digit blank flag: digit i is a leading zero when it and everything above it is 0.
  for (genvar i = 0; i < NDIG; i++) begin : g_lz
`ifdef DISP_LZ_BLANK_EN
    if (i == 0) begin : g_d0
      assign lz[i] = 1'b0;
    end else begin : g_dn
      assign lz[i] = (active[NDIG-1:i] == '0);
    end
`else
    assign lz[i] = 1'b0;
`endif
  end

  // A load coinciding with the wrap bypasses shadow so it shows in the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else if (frame_wrap) begin
      pending <= 1'b0;
      if (load)         active <= value_bcd;
      else if (pending) active <= shadow;
    end else if (load) begin
      shadow  <= value_bcd;
      pending <= 1'b1;
    end
  end

  // frame_tick trails the wrap edge by one clock, so it is a two-stage pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe   <= '0;
      digit_sel  <= '0;
      digit_bcd  <= BLANK_CODE;
    end else begin
      vld_pipe   <= {vld_pipe[0], frame_wrap};
      if (in_guard) begin
        digit_sel <= '0;
        digit_bcd <= BLANK_CODE;
      end else begin
        digit_sel <= NDIG'(1) << idx;
        digit_bcd <= lz[idx] ? BLANK_CODE : active[idx];
      end
    end
  end

  assign frame_tick = vld_pipe[1];
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Scoreboarded bench: driver predicts each cycle's outputs from the cycle number
// and a buffer model; monitor pops and compares one entry per clock.
module tb_disp_scan_ctrl;
  localparam int NDIG = 4, PRESCALE = 8, GUARD = 2;
  localparam int FRAME = NDIG * PRESCALE;
  localparam int RST_AT = 205, TOTAL = 800;

  typedef struct {
    logic [3:0]      bcd;
    logic [NDIG-1:0] sel;
    logic            tick;
    logic            pend;
  } exp_t;

  logic                clk = 1'b0, rst, load;
  logic [4*NDIG-1:0]   value_bcd;
  logic [3:0]          digit_bcd;
  logic [NDIG-1:0]     digit_sel;
  logic                frame_tick, pending;

  int checks = 0, errors = 0;
  exp_t q[$];

  // reference state
  logic [15:0] m_active, m_shadow;
  logic        m_pend;
  int          n;

  disp_scan_ctrl #(.NDIG(NDIG), .PRESCALE(PRESCALE), .GUARD(GUARD)) dut (
    .clk(clk), .rst(rst), .load(load), .value_bcd(value_bcd),
    .digit_bcd(digit_bcd), .digit_sel(digit_sel),
    .frame_tick(frame_tick), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [3:0] shown(input logic [15:0] v, input int d);
    logic [15:0] hi;
    hi = v >> (4 * d);
`ifdef DISP_LZ_BLANK_EN
    if (d > 0 && hi == 16'h0) return 4'hF;
`endif
    return hi[3:0];
  endfunction

  // Expected outputs after edge e (edges counted from reset release), then
  // apply that edge's load/transfer to the model.
  task automatic predict(input int e, input logic ld, input logic [15:0] v);
    exp_t x;
    int s, slot, dig;
    bit wrap;
    s    = (e - 1) % FRAME;
    slot = s % PRESCALE;
    dig  = s / PRESCALE;
    wrap = (e % FRAME) == 0;
    x.tick = (e > FRAME) && (e % FRAME == 1);
    if (slot < GUARD) begin
      x.sel = '0;
      x.bcd = 4'hF;
    end else begin
      x.sel = NDIG'(1 << dig);
      x.bcd = shown(m_active, dig);
    end
    if (ld && wrap) begin
      m_active = v; m_pend = 1'b0;
    end else begin
      if (wrap && m_pend) begin m_active = m_shadow; m_pend = 1'b0; end
      if (ld) begin m_shadow = v; m_pend = 1'b1; end
    end
    x.pend = m_pend;
    q.push_back(x);
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_sel"},  16'(digit_sel),  16'h0);
    chk({tag, "_bcd"},  16'(digit_bcd),  16'hF);
    chk({tag, "_tick"}, 16'(frame_tick), 16'h0);
    chk({tag, "_pend"}, 16'(pending),    16'h0);
  endtask

  // monitor
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("digit_sel",  16'(digit_sel),  16'(x.sel));
        chk("digit_bcd",  16'(digit_bcd),  16'(x.bcd));
        chk("frame_tick", 16'(frame_tick), 16'(x.tick));
        chk("pending",    16'(pending),    16'(x.pend));
      end
    end
  end

  // driver
  initial begin
    logic        ld;
    logic [15:0] v;
    bit          directed;
    rst = 1'b1; load = 1'b0; value_bcd = '0;
    m_active = '0; m_shadow = '0; m_pend = 1'b0;
    repeat (2) @(negedge clk);
    reset_check("reset");
    rst = 1'b0;
    n = 0;
    directed = 1'b1;
    for (int c = 0; c < TOTAL; c++) begin
      if (c == RST_AT) begin
        // mid-slot, with the 16'h4321 load still pending
        #1 rst = 1'b1;
        load = 1'b0;
        #1 reset_check("async_rst");
        @(negedge clk);
        reset_check("rst_hold");
        rst = 1'b0;
        m_active = '0; m_shadow = '0; m_pend = 1'b0;
        n = 0;
        directed = 1'b0;
      end
      ld = 1'b0; v = 16'h0;
      if (directed) begin
        case (n + 1)
          40:  begin ld = 1'b1; v = 16'h1234; end
          70:  begin ld = 1'b1; v = 16'h0007; end
          80:  begin ld = 1'b1; v = 16'h0950; end
          128: begin ld = 1'b1; v = 16'h5678; end
          140: begin ld = 1'b1; v = 16'hA0B1; end
          200: begin ld = 1'b1; v = 16'h4321; end
          default: ;
        endcase
      end else if ($urandom_range(0, 9) == 0) begin
        ld = 1'b1;
        v  = 16'($urandom());
        if ($urandom_range(0, 3) == 0) v = v & 16'h00FF;
      end
      load = ld; value_bcd = v;
      predict(n + 1, ld, v);
      n++;
      @(negedge clk);
    end
    load = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
